// File: rtl/hermes_tx_stage_pkg.sv
// Shared DMNI package for the Hermes transmit output stage.
// Holds the packet-tracking state type and the default credit-stall limit.
package DMNIPkg;

  // Packet tracking: IDLE between packets, BODY after a non-final flit left.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } hermes_tx_state_t;

  localparam int HERMES_STALL_LIMIT_DEFAULT = 1024;

endpackage

// File: rtl/hermes_skid_buffer.sv
// Two-entry FIFO skid buffer for the Hermes transmit stage.
// credit_o and tx_o are decoded from the occupancy register only, so there
// is no combinational path from credit_i to credit_o. No bypass: a flit
// written into an empty buffer shows on tx_o the following cycle.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rx_i, din_i       upstream valid and entry; accepted when rx_i && credit_o
//   credit_o          a slot is free (count != 2)
//   tx_o, dout_o      downstream valid and head entry
//   credit_i          downstream accepts; pops when tx_o && credit_i
module hermes_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             credit_o,
  output logic             tx_o,
  input  logic             credit_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             in_fire;
  logic             out_fire;

  assign credit_o = (count != 2'd2);
  assign tx_o     = (count != 2'd0);
  assign dout_o   = mem[rd_ptr];

  assign in_fire  = rx_i && credit_o;
  assign out_fire = tx_o && credit_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Entries are cleared too so data_o/eop_o read 0 after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_fire) begin
        mem[wr_ptr] <= din_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (out_fire) rd_ptr <= ~rd_ptr;
      case ({in_fire, out_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hermes_tx_stage.sv
// Registered output stage between the DMNI Hermes transmit port and the
// router local input port: skid buffer, packet tracking, credit-stall
// detection and optional flit/packet statistics.
// Build option: define HERMES_TX_STATS_EN to build the flit/packet counters
// and honour clr_stats_i; otherwise the counter outputs are tied to 0.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rx_i, eop_i, data_i, credit_o   DMNI side
//   tx_o, eop_o, data_o, credit_i   router side
//   pkt_active_o                 multi-flit packet partially sent
//   stall_o                      credit withheld for STALL_LIMIT cycles
//   clr_stats_i                  clear statistics counters
//   flit_cnt_o, pkt_cnt_o        flits / packets sent (wrap mod 2^32)
module hermes_tx_stage
  import DMNIPkg::*;
#(
  parameter int HERMES_FLIT_SIZE = 32,
  parameter int STALL_LIMIT      = HERMES_STALL_LIMIT_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rx_i,
  input  logic                        eop_i,
  output logic                        credit_o,
  input  logic [HERMES_FLIT_SIZE-1:0] data_i,
  output logic                        tx_o,
  output logic                        eop_o,
  input  logic                        credit_i,
  output logic [HERMES_FLIT_SIZE-1:0] data_o,
  output logic                        pkt_active_o,
  output logic                        stall_o,
  input  logic                        clr_stats_i,
  output logic [31:0]                 flit_cnt_o,
  output logic [31:0]                 pkt_cnt_o
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

  logic [HERMES_FLIT_SIZE:0] head;
  logic                      out_fire;
  hermes_tx_state_t          state;
  logic [SW-1:0]             stall_cnt;

  hermes_skid_buffer #(.WIDTH(HERMES_FLIT_SIZE + 1)) u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rx_i     (rx_i),
    .din_i    ({eop_i, data_i}),
    .credit_o (credit_o),
    .tx_o     (tx_o),
    .credit_i (credit_i),
    .dout_o   (head)
  );

  assign eop_o    = head[HERMES_FLIT_SIZE];
  assign data_o   = head[HERMES_FLIT_SIZE-1:0];
  assign out_fire = tx_o && credit_i;

  // Packet tracking advances only on flits that actually leave. A final
  // flit always lands in IDLE, which also covers single-flit packets.
  always_ff @(posedge clk_i) begin
    if (rst_i)         state <= IDLE;
    else if (out_fire) state <= eop_o ? IDLE : BODY;
  end

  assign pkt_active_o = (state == BODY);

  // Counts consecutive cycles of pending data without credit; saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || !tx_o || out_fire) stall_cnt <= '0;
    else if (stall_cnt != LIMIT)    stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_o = (stall_cnt == LIMIT);

`ifdef HERMES_TX_STATS_EN
  logic [31:0] flit_cnt;
  logic [31:0] pkt_cnt;

  // Clear wins over a same-cycle transfer; that flit is not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_stats_i) begin
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (out_fire) begin
      flit_cnt <= flit_cnt + 32'd1;
      if (eop_o) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  assign flit_cnt_o = flit_cnt;
  assign pkt_cnt_o  = pkt_cnt;
`else
  logic unused_clr;
  assign unused_clr = clr_stats_i;
  assign flit_cnt_o = '0;
  assign pkt_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hermes_tx_stage.sv
module tb_hermes_tx_stage;
  localparam int W   = 32;
  localparam int LIM = 8;

  logic         clk = 1'b0;
  logic         rst_i, rx_i, eop_i, credit_o, tx_o, eop_o, credit_i;
  logic [W-1:0] data_i, data_o;
  logic         pkt_active_o, stall_o, clr_stats_i;
  logic [31:0]  flit_cnt_o, pkt_cnt_o;

  always #5 clk = ~clk;

  hermes_tx_stage #(.HERMES_FLIT_SIZE(W), .STALL_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .eop_i(eop_i), .credit_o(credit_o),
    .data_i(data_i), .tx_o(tx_o), .eop_o(eop_o), .credit_i(credit_i),
    .data_o(data_o), .pkt_active_o(pkt_active_o), .stall_o(stall_o),
    .clr_stats_i(clr_stats_i), .flit_cnt_o(flit_cnt_o), .pkt_cnt_o(pkt_cnt_o)
  );

  // Reference model: a queue of at most two flits plus simple counters.
  typedef struct packed { logic eop; logic [W-1:0] data; } flit_t;
  flit_t       q[$];
  int          m_stall;
  bit          m_pkt;
  int unsigned m_flits, m_pkts;
  int          vectors = 0, miscompares = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(bit after_reset);
    logic [31:0] ef, ep;
`ifdef HERMES_TX_STATS_EN
    ef = m_flits; ep = m_pkts;
`else
    ef = 0; ep = 0;
`endif
    chk("tx", {31'b0, tx_o}, {31'b0, q.size() != 0});
    chk("credit", {31'b0, credit_o}, {31'b0, q.size() != 2});
    if (q.size() != 0) begin
      chk("data", data_o, q[0].data);
      chk("eop", {31'b0, eop_o}, {31'b0, q[0].eop});
    end else if (after_reset) begin
      chk("rst_data", data_o, 32'h0);
      chk("rst_eop", {31'b0, eop_o}, 32'h0);
    end
    chk("pkt_active", {31'b0, pkt_active_o}, {31'b0, m_pkt});
    chk("stall", {31'b0, stall_o}, {31'b0, m_stall >= LIM});
    chk("flit_cnt", flit_cnt_o, ef);
    chk("pkt_cnt", pkt_cnt_o, ep);
  endtask

  task automatic step(bit rx, bit eop, logic [W-1:0] d, bit cr, bit clr);
    bit    pending, in_f, out_f;
    flit_t h;
    rx_i = rx; eop_i = eop; data_i = d; credit_i = cr; clr_stats_i = clr;
    pending = q.size() != 0;
    in_f    = rx && q.size() != 2;
    out_f   = pending && cr;
    @(posedge clk); #1;
    if (out_f) begin
      h = q.pop_front();
      m_flits++;
      if (h.eop) m_pkts++;
      m_pkt = !h.eop;
    end
    if (clr) begin m_flits = 0; m_pkts = 0; end
    if (in_f) q.push_back(flit_t'{eop: eop, data: d});
    if (pending && !cr) m_stall = (m_stall < LIM) ? m_stall + 1 : LIM;
    else m_stall = 0;
    check_all(1'b0);
  endtask

  task automatic reset_cycles(int n);
    rst_i = 1'b1; rx_i = 1'b1; eop_i = 1'b0; data_i = 32'hDEAD_BEEF;
    credit_i = 1'b1; clr_stats_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      q.delete(); m_stall = 0; m_pkt = 0; m_flits = 0; m_pkts = 0;
      check_all(1'b1);
    end
    rst_i = 1'b0; rx_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; rx_i = 0; eop_i = 0; data_i = '0; credit_i = 0; clr_stats_i = 0;
    m_stall = 0; m_pkt = 0; m_flits = 0; m_pkts = 0;
    reset_cycles(2);

    // 4-flit packet under continuous credit
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, 32'hA0 + i, 1'b1, 1'b0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);

    // backpressure: third flit held off until a slot frees
    step(1, 0, 32'hB0, 0, 0);
    step(1, 0, 32'hB1, 0, 0);
    step(1, 1, 32'hB2, 0, 0);
    step(1, 1, 32'hB2, 1, 0);
    step(1, 1, 32'hB2, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);

    // stall detection and release
    step(1, 1, 32'hC0, 0, 0);
    for (int i = 0; i < LIM + 2; i++) step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);

    // stats clear coincident with an eop transfer
    step(1, 1, 32'hD0, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 0);

    // reset mid-packet: buffered flits must vanish
    step(1, 0, 32'hE0, 0, 0);
    step(1, 0, 32'hE1, 0, 0);
    reset_cycles(2);
    step(0, 0, '0, 1, 0);

    // randomized traffic with a few long credit gaps
    for (int i = 0; i < 400; i++) begin
      bit cr;
      cr = ((i % 100) >= 50 && (i % 100) < 62) ? 1'b0 : ($urandom_range(0, 9) < 6);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom,
           cr, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
